// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, responder side of the EX-stage divide handshake.
// Optional build macro DIV_ANNUL_EN adds annul_i so a pipeline flush can cancel an operation.
module div_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
`ifdef DIV_ANNUL_EN
    input  logic                  annul_i,
`endif
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        StFree,
        StByZero,
        StOn,
        StEnd
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W:0]   dividend_q;
    logic [DATA_W-1:0]   divisor_q;
    logic                op1_neg_q;
    logic                op2_neg_q;
    logic                signed_q;

    logic                annul;
    logic                op1_neg;
    logic                op2_neg;
    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic [DATA_W:0]     diff;
    logic                last_iter;

`ifdef DIV_ANNUL_EN
    assign annul = annul_i;
`else
    assign annul = 1'b0;
`endif

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // Partial remainder lives in dividend_q[2*DATA_W-1:DATA_W]; a set borrow bit means no subtract.
    assign diff      = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    assign last_iter = (cnt_q == CNT_W'(DATA_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFree;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            op1_neg_q  <= 1'b0;
            op2_neg_q  <= 1'b0;
            signed_q   <= 1'b0;
            ready_o    <= 1'b0;
            result_o   <= '0;
        end else begin
            unique case (state_q)
                StFree: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul) begin
                        if (opdata2_i == '0) begin
                            state_q <= StByZero;
                        end else begin
                            state_q    <= StOn;
                            divisor_q  <= op2_abs;
                            dividend_q <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
                            cnt_q      <= '0;
                            op1_neg_q  <= op1_neg;
                            op2_neg_q  <= op2_neg;
                            signed_q   <= signed_div_i;
                        end
                    end
                end

                StByZero: begin
                    if (annul) begin
                        state_q  <= StFree;
                        cnt_q    <= '0;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        dividend_q <= '0;
                        state_q    <= StEnd;
                    end
                end

                StOn: begin
                    if (annul) begin
                        state_q  <= StFree;
                        cnt_q    <= '0;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (!last_iter) begin
                        if (diff[DATA_W]) begin
                            dividend_q <= {dividend_q[2*DATA_W-1:0], 1'b0};
                        end else begin
                            dividend_q <= {diff[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
                        end
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        // Sign fixup: remainder follows the dividend's sign.
                        if (signed_q && (op1_neg_q ^ op2_neg_q)) begin
                            dividend_q[DATA_W-1:0] <= ~dividend_q[DATA_W-1:0] + 1'b1;
                        end
                        if (signed_q && op1_neg_q) begin
                            dividend_q[2*DATA_W:DATA_W+1] <=
                                ~dividend_q[2*DATA_W:DATA_W+1] + 1'b1;
                        end
                        state_q <= StEnd;
                        cnt_q   <= '0;
                    end
                end

                StEnd: begin
                    if (annul || !start_i) begin
                        state_q  <= StFree;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        result_o <= {dividend_q[2*DATA_W:DATA_W+1], dividend_q[DATA_W-1:0]};
                        ready_o  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= StFree;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a driver issues directed divides, a monitor checks results.
module tb_div_unit;

    localparam int LAT   = 34;
    localparam int LAT_Z = 2;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
`ifdef DIV_ANNUL_EN
    logic        annul_i;
`endif

    div_unit #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
`ifdef DIV_ANNUL_EN
        .annul_i      (annul_i),
`endif
        .ready_o      (ready_o)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          pushed = 0;
    int          popped = 0;
    logic [63:0] exp_res_q[$];
    int          exp_cyc_q[$];

    logic [63:0] cur_exp  = '0;
    int          cur_cyc  = 0;
    logic        ready_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each rising ready_o, then checks stability while held.
    initial begin
        forever begin
            @(negedge clk);
            if (ready_o && !ready_prev) begin
                checks++;
                if (exp_res_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: got result=%h, required no ready", result_o);
                end else begin
                    cur_exp = exp_res_q.pop_front();
                    cur_cyc = exp_cyc_q.pop_front();
                    popped++;
                    if (result_o !== cur_exp) begin
                        errors++;
                        $display("FAIL result: got %h, required %h", result_o, cur_exp);
                    end
                    checks++;
                    if (cyc != cur_cyc) begin
                        errors++;
                        $display("FAIL latency: ready at cycle %0d, required %0d", cyc, cur_cyc);
                    end
                end
            end else if (ready_o && ready_prev) begin
                checks++;
                if (result_o !== cur_exp) begin
                    errors++;
                    $display("FAIL hold_stable: got %h, required %h", result_o, cur_exp);
                end
            end
            ready_prev = ready_o;
        end
    end

    task automatic check_idle(input string name);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            errors++;
            $display("FAIL %s: got ready=%b result=%h, required ready=0 result=0",
                     name, ready_o, result_o);
        end
    endtask

    // Issue one divide; hold start_i until ready_o, plus `hold` cycles, then release.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input int lat, input int hold);
        int n;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        exp_res_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 1 + lat);
        pushed++;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready_o && n < 200);
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no ready after %0d cycles, required ready", n);
        end
        for (int i = 0; i < hold; i++) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_idle("release_clears");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
`ifdef DIV_ANNUL_EN
        annul_i      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("idle_after_reset");

        run_op(32'd100,       32'd7,          1'b0, 64'h00000002_0000000E, LAT,   0);
        run_op(32'hFFFFFFF9,  32'h00000002,   1'b1, 64'hFFFFFFFF_FFFFFFFD, LAT,   0);
        run_op(32'd5,         32'd0,          1'b0, 64'h0,                 LAT_Z, 0);
        run_op(32'hFFFFFFFF,  32'd1,          1'b0, 64'h00000000_FFFFFFFF, LAT,   5);
        run_op(32'h80000000,  32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, LAT,   0);
        run_op(32'd7,         32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, LAT,   0);
        run_op(32'hFFFFFFF9,  32'h00000002,   1'b0, 64'h00000001_7FFFFFFC, LAT,   0);
        run_op(32'hFFFFFF9C,  32'hFFFFFFF9,   1'b1, 64'hFFFFFFFE_0000000E, LAT,   2);
        run_op(32'd0,         32'd5,          1'b1, 64'h0,                 LAT,   0);
        run_op(32'hFFFFFFFB,  32'd0,          1'b1, 64'h0,                 LAT_Z, 0);

        // Reset while the iteration counter reads 10.
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_idle("reset_mid_op");
        rst = 1'b0;
        run_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, LAT, 0);

`ifdef DIV_ANNUL_EN
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check_idle("annul_mid_op");
        repeat (40) @(posedge clk);
        #1;
        check_idle("annul_no_ready");
        run_op(32'd10, 32'd4, 1'b0, 64'h00000002_00000002, LAT, 0);
`endif

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_res_q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d completed, required %0d", popped, pushed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
